// File: rtl/led_scan_buf.sv
// led_scan_buf: keeps the last four received ASCII characters and scans them onto one digit bus.
// Optional build macro LED_SCAN_DIGIT_FILTER_EN: drop non-digit bytes and pulse rx_drop.
module led_scan_buf #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] data,
    output logic [3:0] sel,
    output logic       frame,
    output logic       rx_drop
);
    localparam logic [7:0]       ASCII_ZERO = 8'h30;
    localparam logic [7:0]       ASCII_ESC  = 8'h1B;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);

    // rx_valid is a one-cycle strobe with no ready: every strobe is consumed in the cycle it appears.
    logic [7:0]       digits_q [4];
    logic [7:0]       digits_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             tc;
    logic             frame_d;
`ifdef LED_SCAN_DIGIT_FILTER_EN
    logic             drop_d;
`endif

    always_comb begin
        tc       = (cnt_q == CNT_LAST);
        cnt_d    = tc ? '0 : cnt_q + 1'b1;
        idx_d    = tc ? idx_q + 2'd1 : idx_q;
        frame_d  = tc && (idx_q == 2'd3);
        digits_d = digits_q;
`ifdef LED_SCAN_DIGIT_FILTER_EN
        drop_d   = 1'b0;
`endif
        if (rx_valid) begin
            if (rx_data == ASCII_ESC) begin
                for (int i = 0; i < 4; i++) digits_d[i] = ASCII_ZERO;
            end
`ifdef LED_SCAN_DIGIT_FILTER_EN
            else if (rx_data inside {[8'h30:8'h39]}) begin
                digits_d[3] = digits_q[2];
                digits_d[2] = digits_q[1];
                digits_d[1] = digits_q[0];
                digits_d[0] = rx_data;
            end else begin
                drop_d = 1'b1;
            end
`else
            else begin
                digits_d[3] = digits_q[2];
                digits_d[2] = digits_q[1];
                digits_d[1] = digits_q[0];
                digits_d[0] = rx_data;
            end
`endif
        end
    end

    // data is taken from next-state buffer and index so it never lags sel or a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) digits_q[i] <= ASCII_ZERO;
            cnt_q <= '0;
            idx_q <= '0;
            data  <= ASCII_ZERO;
            frame <= 1'b0;
        end else begin
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data     <= digits_d[idx_d];
            frame    <= frame_d;
        end
    end

    assign sel = {2'b00, idx_q};

`ifdef LED_SCAN_DIGIT_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_drop <= 1'b0;
        else     rx_drop <= drop_d;
    end
`else
    assign rx_drop = 1'b0;
`endif

endmodule

// File: tb/tb_led_scan_buf.sv
// tb_led_scan_buf: directed stimulus with a per-cycle scoreboard and literal spot checks.
module tb_led_scan_buf;
    localparam int SCAN_DIV = 4;
`ifdef LED_SCAN_DIGIT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] data;
    logic [3:0] sel;
    logic       frame;
    logic       rx_drop;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    logic [7:0] m_buf [4];
    int         m_cnt = 0;
    int         m_sel = 0;
    logic       m_frame = 1'b0;
    logic       m_drop = 1'b0;

    led_scan_buf #(.SCAN_DIV(SCAN_DIV), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .data(data), .sel(sel), .frame(frame), .rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one expected output word per rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_buf[i] = 8'h30;
            m_cnt = 0; m_sel = 0; m_frame = 1'b0; m_drop = 1'b0;
        end else begin
            m_frame = (m_cnt == SCAN_DIV - 1) && (m_sel == 3);
            m_drop  = 1'b0;
            if (rx_valid) begin
                if (rx_data == 8'h1B) begin
                    for (int i = 0; i < 4; i++) m_buf[i] = 8'h30;
                end else if (FILTER && !(rx_data >= 8'h30 && rx_data <= 8'h39)) begin
                    m_drop = 1'b1;
                end else begin
                    m_buf[3] = m_buf[2]; m_buf[2] = m_buf[1];
                    m_buf[1] = m_buf[0]; m_buf[0] = rx_data;
                end
            end
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_sel = (m_sel + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back({m_buf[m_sel], 4'(m_sel), m_frame, m_drop});
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {2'b00, data, sel, frame, rx_drop}, {2'b00, e});
        end
    end

    task automatic send_seq(input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = bytes[8*i +: 8];
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic scan_expect(input string name, input logic [31:0] exp_word);
        int idx;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge clk);
            idx = int'(sel[1:0]) * 8;
            check(name, data, exp_word[idx +: 8]);
        end
    endtask

    task automatic wait_sel(input logic [3:0] k);
        int n = 0;
        @(negedge clk);
        while (sel == k && n < 50) begin @(negedge clk); n++; end
        while (sel != k && n < 50) begin @(negedge clk); n++; end
        check("wait_sel_timeout", 16'(n < 50), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_data", data, 8'h30);
        check("reset_sel", sel, 4'd0);
        check("reset_frame", frame, 1'b0);
        check("reset_drop", rx_drop, 1'b0);
        rst = 1'b0;

        // Idle scan: each digit held 4 cycles, frame on the first sample after 3->0.
        for (int i = 0; i <= 16; i++) begin
            check("idle_sel", sel, 16'((i / 4) % 4));
            check("idle_data", data, 8'h30);
            check("idle_frame", frame, 16'(i == 16));
            @(negedge clk); #1;
        end

        send_seq(32'h34333231, 4);
        scan_expect("buf_1234", 32'h31323334);
        send_seq(32'h00000035, 1);
        scan_expect("buf_5", 32'h32333435);

        send_seq(32'h00000041, 1);
        @(negedge clk);
        check("drop_pulse", rx_drop, 16'(FILTER));
        @(negedge clk);
        check("drop_clear", rx_drop, 1'b0);
        if (FILTER) scan_expect("buf_after_A", 32'h32333435);
        else        scan_expect("buf_after_A", 32'h33343541);

        wait_sel(4'd2);
        send_seq(32'h0000001B, 1);
        @(negedge clk);
        check("esc_sel", sel, 4'd2);
        check("esc_data", data, 8'h30);
        check("esc_no_drop", rx_drop, 1'b0);
        scan_expect("buf_esc", 32'h30303030);

        // Write landing on the terminal-count edge at sel=3.
        wait_sel(4'd3);
        repeat (3) @(posedge clk);
        #1; rx_valid = 1'b1; rx_data = 8'h37;
        @(posedge clk); #1; rx_valid = 1'b0;
        @(negedge clk);
        check("tc_sel", sel, 4'd0);
        check("tc_data", data, 8'h37);
        check("tc_frame", frame, 1'b1);

        // Reset mid-hold at sel=3, divider=2 with a non-zero character selected.
        send_seq(32'h00383736, 3);
        wait_sel(4'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_data", data, 8'h37);
        #1; rst = 1'b1;
        #1;
        check("rst_data", data, 8'h30);
        check("rst_sel", sel, 4'd0);
        check("rst_frame", frame, 1'b0);
        check("rst_drop", rx_drop, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            check("post_rst_sel", sel, 16'(i / 4));
            check("post_rst_data", data, 8'h30);
            @(negedge clk); #1;
        end
        scan_expect("buf_post_rst", 32'h30303030);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
